// File: rtl/pipe_hazard_ctrl.sv
// IF/ID hazard controller: load-use stalls, branch/jump flushes and instruction-memory waits.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       branch_taken,
  input  logic       jump_id,
  input  logic       imem_ready,
  output logic       stall,
  output logic       flush,
  output logic       pc_hold,
  output logic       id_ex_bubble,
  output logic [1:0] state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_cycles
`endif
);

  typedef enum logic [1:0] {
    StRun       = 2'b00,
    StLoadStall = 2'b01,
    StFlush     = 2'b10,
    StImemWait  = 2'b11
  } state_e;

  localparam logic [2:0] LoadLat = 3'(LOAD_LAT);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       lu;

  assign lu    = ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (branch_taken) begin
      state_d = StFlush;
      cnt_d   = 3'd0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (lu) begin
            state_d = StLoadStall;
            cnt_d   = 3'd1;
          end else if (!imem_ready) begin
            state_d = StImemWait;
            cnt_d   = 3'd0;
          end else begin
            state_d = StRun;
            cnt_d   = 3'd0;
          end
        end
        StLoadStall: begin
          // Counter stops at LoadLat (<= 7), so it can never wrap.
          if (cnt_q < LoadLat) begin
            cnt_d = cnt_q + 3'd1;
          end else begin
            state_d = StRun;
            cnt_d   = 3'd0;
          end
        end
        StFlush: begin
          state_d = StRun;
          cnt_d   = 3'd0;
        end
        StImemWait: begin
          if (imem_ready) begin
            state_d = StRun;
            cnt_d   = 3'd0;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall        = 1'b0;
    flush        = 1'b0;
    pc_hold      = 1'b0;
    id_ex_bubble = 1'b0;
    if (reset) begin
      flush        = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (branch_taken) begin
      flush        = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (lu) begin
            stall        = 1'b1;
            pc_hold      = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (!imem_ready) begin
            pc_hold = 1'b1;
            flush   = 1'b1;
          end else if (jump_id) begin
            flush = 1'b1;
          end
        end
        StLoadStall: begin
          if (cnt_q < LoadLat) begin
            stall        = 1'b1;
            pc_hold      = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        StFlush: begin
          flush = 1'b1;
        end
        StImemWait: begin
          if (!imem_ready) begin
            pc_hold = 1'b1;
            flush   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 16'd0;
      flush_cycles <= 16'd0;
    end else begin
      if (stall && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
      if (flush && (flush_cycles != 16'hFFFF)) flush_cycles <= flush_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with LOAD_LAT=1 and LOAD_LAT=3 instances sharing inputs.
module tb_pipe_hazard_ctrl;
  logic       clk;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_mem_read, branch_taken, jump_id, imem_ready;

  logic       a_stall, a_flush, a_pc_hold, a_bubble;
  logic [1:0] a_state;
  logic       b_stall, b_flush, b_pc_hold, b_bubble;
  logic [1:0] b_state;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] a_sc, a_fc, b_sc, b_fc, c_sc, c_fc;
  logic        c_stall, c_flush, c_pc_hold, c_bubble;
  logic [1:0]  c_state;
`endif

  pipe_hazard_ctrl #(.LOAD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .jump_id(jump_id),
    .imem_ready(imem_ready), .stall(a_stall), .flush(a_flush), .pc_hold(a_pc_hold),
    .id_ex_bubble(a_bubble), .state(a_state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(a_sc), .flush_cycles(a_fc)
`endif
  );

  pipe_hazard_ctrl #(.LOAD_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .jump_id(jump_id),
    .imem_ready(imem_ready), .stall(b_stall), .flush(b_flush), .pc_hold(b_pc_hold),
    .id_ex_bubble(b_bubble), .state(b_state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(b_sc), .flush_cycles(b_fc)
`endif
  );

`ifdef HAZARD_PERF_CNT_EN
  pipe_hazard_ctrl #(.LOAD_LAT(7)) u_lat7 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .jump_id(jump_id),
    .imem_ready(imem_ready), .stall(c_stall), .flush(c_flush), .pc_hold(c_pc_hold),
    .id_ex_bubble(c_bubble), .state(c_state), .stall_cycles(c_sc), .flush_cycles(c_fc)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic en);
    ex_mem_read = en;
    ex_rd       = 5'd5;
    id_rs1      = 5'd1;
    id_rs2      = 5'd5;
  endtask

  initial begin
    reset = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    ex_mem_read = 1'b0; branch_taken = 1'b0; jump_id = 1'b0; imem_ready = 1'b1;
    #2;
    check_eq("rst_state", a_state, 2'b00);
    check_eq("rst_stall", a_stall, 1'b0);
    check_eq("rst_pc_hold", a_pc_hold, 1'b0);
    check_eq("rst_flush", a_flush, 1'b1);
    check_eq("rst_bubble", a_bubble, 1'b1);
    step(); step();
    reset = 1'b0;
    #1;
    check_eq("idle_flush", a_flush, 1'b0);
    check_eq("idle_bubble", b_bubble, 1'b0);

    // Load-use on rs2
    step(); set_lu(1'b1); #1;
    check_eq("lu_a_stall0", a_stall, 1'b1);
    check_eq("lu_a_state0", a_state, 2'b00);
    check_eq("lu_b_stall0", b_stall, 1'b1);
    check_eq("lu_b_flush0", b_flush, 1'b0);
    step(); set_lu(1'b0); #1;
    check_eq("lu_a_state1", a_state, 2'b01);
    check_eq("lu_a_stall1", a_stall, 1'b0);
    check_eq("lu_b_state1", b_state, 2'b01);
    check_eq("lu_b_stall1", b_stall, 1'b1);
    step(); #1;
    check_eq("lu_a_state2", a_state, 2'b00);
    check_eq("lu_b_stall2", b_stall, 1'b1);
    check_eq("lu_b_pc_hold2", b_pc_hold, 1'b1);
    check_eq("lu_b_bubble2", b_bubble, 1'b1);
    step(); #1;
    check_eq("lu_b_state3", b_state, 2'b01);
    check_eq("lu_b_stall3", b_stall, 1'b0);
    check_eq("lu_b_pc_hold3", b_pc_hold, 1'b0);
    check_eq("lu_b_bubble3", b_bubble, 1'b0);
    step(); #1;
    check_eq("lu_b_state4", b_state, 2'b00);

    // x0 destination and non-load matches never stall
    step(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; #1;
    check_eq("x0_stall", a_stall, 1'b0);
    step(); ex_mem_read = 1'b0; ex_rd = 5'd5; id_rs2 = 5'd5; #1;
    check_eq("x0_state", a_state, 2'b00);
    check_eq("noload_stall", b_stall, 1'b0);

    // Branch beats load-use
    step(); set_lu(1'b1); branch_taken = 1'b1; #1;
    check_eq("br_flush0", a_flush, 1'b1);
    check_eq("br_stall0", a_stall, 1'b0);
    check_eq("br_bubble0", b_bubble, 1'b1);
    check_eq("br_pc_hold0", b_pc_hold, 1'b0);
    step(); branch_taken = 1'b0; set_lu(1'b0); #1;
    check_eq("br_state1", a_state, 2'b10);
    check_eq("br_flush1", a_flush, 1'b1);
    check_eq("br_stall1", b_stall, 1'b0);
    step(); #1;
    check_eq("br_state2", b_state, 2'b00);
    check_eq("br_flush2", a_flush, 1'b0);

    // Three cycles of imem wait
    step(); imem_ready = 1'b0; #1;
    check_eq("im_pc_hold0", a_pc_hold, 1'b1);
    check_eq("im_flush0", a_flush, 1'b1);
    step(); #1;
    check_eq("im_state1", a_state, 2'b11);
    check_eq("im_pc_hold1", a_pc_hold, 1'b1);
    step(); #1;
    check_eq("im_flush2", b_flush, 1'b1);
    check_eq("im_stall2", b_stall, 1'b0);
    step(); imem_ready = 1'b1; #1;
    check_eq("im_state3", a_state, 2'b11);
    check_eq("im_pc_hold3", a_pc_hold, 1'b0);
    check_eq("im_flush3", a_flush, 1'b0);
    step(); #1;
    check_eq("im_state4", a_state, 2'b00);

    // Branch during imem wait
    step(); imem_ready = 1'b0; #1;
    check_eq("imbr_pc_hold0", a_pc_hold, 1'b1);
    step(); branch_taken = 1'b1; #1;
    check_eq("imbr_state1", a_state, 2'b11);
    check_eq("imbr_pc_hold1", a_pc_hold, 1'b0);
    check_eq("imbr_flush1", a_flush, 1'b1);
    step(); branch_taken = 1'b0; imem_ready = 1'b1; #1;
    check_eq("imbr_state2", a_state, 2'b10);
    check_eq("imbr_flush2", a_flush, 1'b1);
    step(); #1;
    check_eq("imbr_state3", a_state, 2'b00);

    // Jump flush, and jump losing to load-use
    step(); jump_id = 1'b1; #1;
    check_eq("jmp_flush", a_flush, 1'b1);
    check_eq("jmp_pc_hold", a_pc_hold, 1'b0);
    check_eq("jmp_bubble", a_bubble, 1'b0);
    step(); jump_id = 1'b0; #1;
    check_eq("jmp_state", a_state, 2'b00);
    check_eq("jmp_flush_off", a_flush, 1'b0);
    step(); jump_id = 1'b1; set_lu(1'b1); #1;
    check_eq("jmplu_stall", a_stall, 1'b1);
    check_eq("jmplu_flush", a_flush, 1'b0);
    step(); jump_id = 1'b0; set_lu(1'b0); #1;
    check_eq("rstls_pre", b_state, 2'b01);

    // Asynchronous reset abandons the load stall
    reset = 1'b1; #1;
    check_eq("rstls_state", b_state, 2'b00);
    check_eq("rstls_stall", b_stall, 1'b0);
    check_eq("rstls_flush", b_flush, 1'b1);
    step(); reset = 1'b0; #1;
    check_eq("rstls_idle", b_stall, 1'b0);
    step(); set_lu(1'b1); #1;
    check_eq("post_rst_stall", b_stall, 1'b1);
    step(); set_lu(1'b0); #1;
    check_eq("post_rst_state", b_state, 2'b01);

`ifdef HAZARD_PERF_CNT_EN
    reset = 1'b1; #1;
    check_eq("perf_clr", c_sc, 16'd0);
    step(); reset = 1'b0; set_lu(1'b1);
    // LOAD_LAT=7 stalls 7 of every 8 cycles: 76000 cycles exceed 65535 stalls
    repeat (76000) @(posedge clk);
    #1;
    check_eq("perf_stall_sat", c_sc, 16'hFFFF);
    check_eq("perf_flush", c_fc, 16'd0);
    set_lu(1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: LOAD_LAT, default 1, range 1..7; extra cycles a load needs before its result can be forwarded.
REQ-002 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: id_rs1, id_rs2  in  5 each  source register indices of the instruction held in IF/ID.
REQ-005 Port: ex_rd  in  5  destination register index of the instruction in EX.
REQ-006 Port: ex_mem_read  in  1  instruction in EX is a load.
REQ-007 Port: branch_taken  in  1  branch resolved taken in EX.
REQ-008 Port: jump_id  in  1  jump decoded in ID, i.e. jump_IF_ID.
REQ-009 Port: imem_ready  in  1  instruction memory word valid this cycle.
REQ-010 Port: stall  out  1  drives IF/ID stall (hold contents).
REQ-011 Port: flush  out  1  drives IF/ID flush (zero contents).
REQ-012 Port: pc_hold  out  1  PC keeps its current value.
REQ-013 Port: id_ex_bubble  out  1  ID/EX loads a NOP.
REQ-014 Port: state  out  2  current FSM state encoding.

Function
REQ-015 The FSM SHALL have states RUN=00, LOAD_STALL=01, FLUSH=10 and IMEM_WAIT=11.
REQ-016 Outputs SHALL be combinational (Mealy) from the current state and inputs; state and counter SHALL be registered.
REQ-017 Load-use hazard (lu) SHALL be defined as ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
REQ-018 Event priority, in every state, SHALL be branch_taken > lu > !imem_ready > jump_id.
REQ-019 Any state with branch_taken=1 SHALL give flush=1, id_ex_bubble=1, stall=0 and pc_hold=0, with next state FLUSH and the counter cleared.
REQ-020 RUN with lu SHALL give stall=1, pc_hold=1 and id_ex_bubble=1, with next state LOAD_STALL and counter=1.
REQ-021 LOAD_STALL SHALL keep stall=1, pc_hold=1 and id_ex_bubble=1 while counter<LOAD_LAT, incrementing the counter each cycle.
REQ-022 LOAD_STALL with counter==LOAD_LAT SHALL deassert all outputs and go to RUN; a stall SHALL total exactly LOAD_LAT cycles.
REQ-023 FLUSH SHALL assert flush=1 for exactly one further cycle (squashing the second wrong-path fetch), then go to RUN.
REQ-024 RUN with !imem_ready SHALL give pc_hold=1 and flush=1, with next state IMEM_WAIT.
REQ-025 IMEM_WAIT SHALL hold those outputs until imem_ready=1, then deassert them in that cycle and go to RUN.
REQ-026 RUN with jump_id and no higher-priority event SHALL give flush=1 for one cycle and stay in RUN.
REQ-027 stall and flush SHALL never both be 1 in the same cycle.
REQ-028 The counter SHALL be 3 bits and SHALL never wrap; it is cleared on every entry to RUN.

Reset
REQ-029 While reset=1: state=RUN, counter=0, stall=0, pc_hold=0, flush=1, id_ex_bubble=1.
REQ-030 Reset asserted mid-LOAD_STALL, FLUSH or IMEM_WAIT SHALL abandon the sequence immediately.
REQ-031 The first edge after reset deasserts SHALL evaluate from RUN.

Configuration
REQ-032 With HAZARD_PERF_CNT_EN defined, the block SHALL add outputs stall_cycles (16) and flush_cycles (16).
REQ-033 Each counter SHALL increment on every clock where stall or flush respectively is 1, saturate at 16'hFFFF, and clear on reset.
REQ-034 Without HAZARD_PERF_CNT_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 LOAD_LAT=1, ex_mem_read=1, ex_rd=5, id_rs2=5 -> stall=1 for 1 cycle, state 00->01->00.
REQ-036 LOAD_LAT=3, same hazard -> stall, pc_hold and bubble high for exactly 3 cycles.
REQ-037 ex_rd=0 with ex_mem_read=1 and id_rs1=0 -> no stall.
REQ-038 branch_taken=1 together with lu -> flush=1 and stall=0 for 2 cycles, state 00->10->00.
REQ-039 Three cycles of imem_ready=0 -> pc_hold=1 and flush=1 for 3 cycles, with branch_taken in cycle 2 -> state goes to FLUSH and pc_hold drops.
REQ-040 reset pulsed in LOAD_STALL -> state=00 at once; with HAZARD_PERF_CNT_EN, 70000 stall cycles -> stall_cycles=16'hFFFF.
